text_scroll: RTL and testbench

TEXT_SCROLL -- requirements
Module: text_scroll

---
 rtl/text_scroll.sv | 155 +++++++++++++++
 tb/tb_text_scroll.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_scroll.sv
// rtl/text_scroll.sv - scrolling text tile layer with CPU-visible tile table and control registers
// CPU side is written on negedge; the display path is a 2-stage posedge pipeline.

module text_scroll #(
   parameter int          ROWS       = 30,
   parameter logic [11:0] TXBL_BASE  = 12'h900,
   parameter int          BLINK_LOG2 = 5
) (
   input  logic        cpu_clk,
   input  logic        rst,
   input  logic [7:0]  display_x_i,
   input  logic [7:0]  display_y_i,
   input  logic        frame_start_i,
   output logic        display_color_o,
   output logic        display_valid_o,
   input  logic [7:0]  vram_wdata_i,
   output logic [7:0]  vram_rdata_o,
   input  logic [11:0] vram_address_i,
   input  logic        vram_wen_i,
   input  logic        SELECT_txbl_i,
   input  logic        SELECT_txctl_i
);

   localparam logic [8:0] WRAP = 9'(ROWS * 8);

   logic [7:0] txbl_mem [1024];
   logic [7:0] pmc_mem  [1024];

   logic [9:0] txbl_idx;
   logic       reg_wen;

   logic [1:0] ctrl_q, ctrl_d;
   logic [7:0] scrx_q, scrx_d;
   logic [7:0] scry_q, scry_d;

   logic [7:0] shadow_x_q, shadow_x_d;
   logic [7:0] shadow_y_q, shadow_y_d;
   logic [1:0] shadow_ctrl_q, shadow_ctrl_d;
   logic [7:0] fcnt_q, fcnt_d;
   logic [7:0] sx_q, sx_d;
   logic [7:0] sy_q, sy_d;
   logic       s1_live_q, s1_live_d;
   logic       valid_q, valid_d;
   logic       color_q, color_d;

   logic [8:0] sum_y;
   logic [7:0] tile;
   logic [7:0] line;
   logic       pix;

   assign txbl_idx = 10'(vram_address_i - TXBL_BASE);
   // A write with both selects high goes to the tile table only.
   assign reg_wen  = vram_wen_i & SELECT_txctl_i & ~SELECT_txbl_i;

   always_comb begin
      ctrl_d = ctrl_q;
      scrx_d = scrx_q;
      scry_d = scry_q;
      if (reg_wen) begin
         case (vram_address_i[1:0])
            2'd0:    ctrl_d = vram_wdata_i[1:0];
            2'd1:    scrx_d = vram_wdata_i;
            2'd2:    scry_d = ({1'b0, vram_wdata_i} >= WRAP) ?
                              8'({1'b0, vram_wdata_i} - WRAP) : vram_wdata_i;
            default: ;
         endcase
      end
   end

   always_ff @(negedge cpu_clk or posedge rst) begin
      if (rst) begin
         ctrl_q <= 2'b01;
         scrx_q <= 8'h00;
         scry_q <= 8'h00;
      end else begin
         ctrl_q <= ctrl_d;
         scrx_q <= scrx_d;
         scry_q <= scry_d;
      end
   end

   always_ff @(negedge cpu_clk) begin
      if (vram_wen_i && SELECT_txbl_i) begin
         txbl_mem[txbl_idx] <= vram_wdata_i;
      end
   end

   always_comb begin
      vram_rdata_o = 8'h00;
      if (SELECT_txbl_i) begin
         vram_rdata_o = txbl_mem[txbl_idx];
      end else if (SELECT_txctl_i) begin
         case (vram_address_i[1:0])
            2'd0:    vram_rdata_o = {6'b0, ctrl_q};
            2'd1:    vram_rdata_o = scrx_q;
            2'd2:    vram_rdata_o = scry_q;
            default: vram_rdata_o = fcnt_q;
         endcase
      end
   end

   always_comb begin
      shadow_x_d    = shadow_x_q;
      shadow_y_d    = shadow_y_q;
      shadow_ctrl_d = shadow_ctrl_q;
      fcnt_d        = fcnt_q;
      if (frame_start_i) begin
         shadow_x_d    = scrx_q;
         shadow_y_d    = scry_q;
         shadow_ctrl_d = ctrl_q;
         fcnt_d        = fcnt_q + 8'd1;
      end

      sx_d      = display_x_i + shadow_x_q;
      sum_y     = {1'b0, display_y_i} + {1'b0, shadow_y_q};
      sy_d      = (sum_y >= WRAP) ? 8'(sum_y - WRAP) : sum_y[7:0];
      s1_live_d = 1'b1;

      // Stage 2 reads the tile table live, so a write lands on the next sample.
      tile    = txbl_mem[{sy_q[7:3], sx_q[7:3]}];
      line    = pmc_mem[{tile[6:0], sy_q[2:0]}];
      pix     = line[3'd7 - sx_q[2:0]];
      valid_d = s1_live_q & pix & shadow_ctrl_q[0] &
                ~(shadow_ctrl_q[1] & tile[7] & fcnt_q[BLINK_LOG2-1]);
      color_d = valid_d & tile[7];
   end

   always_ff @(posedge cpu_clk or posedge rst) begin
      if (rst) begin
         shadow_x_q    <= 8'h00;
         shadow_y_q    <= 8'h00;
         shadow_ctrl_q <= 2'b00;
         fcnt_q        <= 8'h00;
         sx_q          <= 8'h00;
         sy_q          <= 8'h00;
         s1_live_q     <= 1'b0;
         valid_q       <= 1'b0;
         color_q       <= 1'b0;
      end else begin
         shadow_x_q    <= shadow_x_d;
         shadow_y_q    <= shadow_y_d;
         shadow_ctrl_q <= shadow_ctrl_d;
         fcnt_q        <= fcnt_d;
         sx_q          <= sx_d;
         sy_q          <= sy_d;
         s1_live_q     <= s1_live_d;
         valid_q       <= valid_d;
         color_q       <= color_d;
      end
   end

   assign display_valid_o = valid_q;
   assign display_color_o = color_q;

endmodule

// File: tb/tb_text_scroll.sv
// tb/tb_text_scroll.sv - randomized and directed checks of text_scroll against a pixel-level model
// The model tracks registers, tile table and a one-deep pending pixel; outputs are compared every cycle.

module tb_text_scroll;

   localparam int          ROWS = 30;
   localparam logic [11:0] BASE = 12'h900;
   localparam int          BL   = 5;
   localparam int          WRAP = ROWS * 8;

   logic        cpu_clk        = 1'b0;
   logic        rst            = 1'b0;
   logic [7:0]  display_x_i    = 8'h00;
   logic [7:0]  display_y_i    = 8'h00;
   logic        frame_start_i  = 1'b0;
   logic        display_color_o;
   logic        display_valid_o;
   logic [7:0]  vram_wdata_i   = 8'h00;
   logic [7:0]  vram_rdata_o;
   logic [11:0] vram_address_i = 12'h000;
   logic        vram_wen_i     = 1'b0;
   logic        SELECT_txbl_i  = 1'b0;
   logic        SELECT_txctl_i = 1'b0;

   text_scroll #(.ROWS(ROWS), .TXBL_BASE(BASE), .BLINK_LOG2(BL)) dut (
      .cpu_clk        (cpu_clk),
      .rst            (rst),
      .display_x_i    (display_x_i),
      .display_y_i    (display_y_i),
      .frame_start_i  (frame_start_i),
      .display_color_o(display_color_o),
      .display_valid_o(display_valid_o),
      .vram_wdata_i   (vram_wdata_i),
      .vram_rdata_o   (vram_rdata_o),
      .vram_address_i (vram_address_i),
      .vram_wen_i     (vram_wen_i),
      .SELECT_txbl_i  (SELECT_txbl_i),
      .SELECT_txctl_i (SELECT_txctl_i)
   );

   always #5 cpu_clk = ~cpu_clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] m_txbl [1024];
   logic [7:0] m_pmc  [1024];
   logic [1:0] m_ctrl, m_shc;
   logic [7:0] m_scrx, m_scry, m_fcnt, m_shx, m_shy;
   logic       p_live;
   int         p_sx, p_sy;
   logic       exp_v = 1'b0;
   logic       exp_c = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
   endtask

   // What the screen shows at scrolled coordinate (sx, sy) under the current shadow state.
   function automatic logic [1:0] pixel(input int sx, input int sy);
      logic [7:0] tile, line;
      logic       on;
      tile = m_txbl[(sy / 8) * 32 + sx / 8];
      line = m_pmc[int'(tile[6:0]) * 8 + sy % 8];
      on   = line[7 - sx % 8];
      if (!m_shc[0]) on = 1'b0;
      if (m_shc[1] && tile[7] && m_fcnt[BL-1]) on = 1'b0;
      return {on, on & tile[7]};
   endfunction

   function automatic logic [7:0] model_rdata();
      if (SELECT_txbl_i) return m_txbl[(int'(vram_address_i) - int'(BASE)) & 1023];
      if (SELECT_txctl_i) begin
         case (vram_address_i[1:0])
            2'd0:    return {6'b0, m_ctrl};
            2'd1:    return m_scrx;
            2'd2:    return m_scry;
            default: return m_fcnt;
         endcase
      end
      return 8'h00;
   endfunction

   task automatic model_reset();
      m_ctrl = 2'b01; m_scrx = 8'h00; m_scry = 8'h00; m_fcnt = 8'h00;
      m_shc  = 2'b00; m_shx  = 8'h00; m_shy  = 8'h00;
      p_live = 1'b0;  p_sx   = 0;     p_sy   = 0;
      exp_v  = 1'b0;  exp_c  = 1'b0;
   endtask

   task automatic model_negedge();
      int s;
      if (rst) begin
         exp_v = 1'b0; exp_c = 1'b0; p_live = 1'b0;
         return;
      end
      if (vram_wen_i && SELECT_txbl_i) begin
         m_txbl[(int'(vram_address_i) - int'(BASE)) & 1023] = vram_wdata_i;
      end else if (vram_wen_i && SELECT_txctl_i) begin
         case (vram_address_i[1:0])
            2'd0:    m_ctrl = vram_wdata_i[1:0];
            2'd1:    m_scrx = vram_wdata_i;
            2'd2:    m_scry = (int'(vram_wdata_i) >= WRAP) ? 8'(int'(vram_wdata_i) - WRAP) : vram_wdata_i;
            default: ;
         endcase
      end
      {exp_v, exp_c} = p_live ? pixel(p_sx, p_sy) : 2'b00;
      p_sx = (int'(display_x_i) + int'(m_shx)) % 256;
      s    = int'(display_y_i) + int'(m_shy);
      if (s >= WRAP) s -= WRAP;
      p_sy   = s;
      p_live = 1'b1;
      if (frame_start_i) begin
         m_shx = m_scrx; m_shy = m_scry; m_shc = m_ctrl;
         m_fcnt = m_fcnt + 8'd1;
      end
   endtask

   always begin
      @(posedge cpu_clk);
      #1;
      chk("display_valid", 32'(display_valid_o), 32'(exp_v));
      chk("display_color", 32'(display_color_o), 32'(exp_c));
   end

   task automatic step();
      @(negedge cpu_clk);
      model_negedge();
      @(posedge cpu_clk);
      #2;
   endtask

   task automatic wr(input logic t, input logic c, input logic [11:0] a, input logic [7:0] d);
      SELECT_txbl_i = t; SELECT_txctl_i = c; vram_address_i = a; vram_wdata_i = d; vram_wen_i = 1'b1;
      step();
      vram_wen_i = 1'b0; SELECT_txbl_i = 1'b0; SELECT_txctl_i = 1'b0;
   endtask

   task automatic frame();
      frame_start_i = 1'b1;
      step();
      frame_start_i = 1'b0;
   endtask

   task automatic show(input logic [7:0] x, input logic [7:0] y, input int n);
      display_x_i = x; display_y_i = y;
      repeat (n) step();
   endtask

   task automatic chk_rd(input string name, input logic t, input logic c, input logic [11:0] a, input logic [7:0] expv);
      SELECT_txbl_i = t; SELECT_txctl_i = c; vram_address_i = a;
      #1;
      chk(name, 32'(vram_rdata_o), 32'(expv));
      SELECT_txbl_i = 1'b0; SELECT_txctl_i = 1'b0;
      step();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         m_pmc[i] = 8'($urandom);
         if (i < 8) m_pmc[i] = 8'h00;
         if (i == 8) m_pmc[i] = 8'h80;
         if (i == 9) m_pmc[i] = 8'hFF;
         dut.pmc_mem[i] = m_pmc[i];
      end
      model_reset();
      #1 rst = 1'b1;
      step(); step();
      chk("reset_valid", 32'(display_valid_o), 32'h0);
      chk_rd("reset_ctrl", 1'b0, 1'b1, 12'h000, 8'h01);
      chk_rd("reset_scry", 1'b0, 1'b1, 12'h002, 8'h00);
      rst = 1'b0;
      step();

      for (int i = 0; i < 1024; i++) begin
         logic [7:0] d;
         d = 8'($urandom);
         if (i == 0) d = 8'h81;
         if (i == 1) d = 8'h00;
         if (i == 2) d = 8'h01;
         wr(1'b1, 1'b0, 12'(int'(BASE) + i), d);
      end

      // Single lit pixel at the origin.
      frame();
      show(8'd0, 8'd0, 3);
      chk("origin_valid", 32'(display_valid_o), 32'h1);
      chk("origin_color", 32'(display_color_o), 32'h1);
      show(8'd1, 8'd0, 2);
      chk("x1_valid", 32'(display_valid_o), 32'h0);

      // Horizontal scroll is held off until the next frame start.
      show(8'd0, 8'd0, 2);
      wr(1'b0, 1'b1, 12'h001, 8'h08);
      step(); step();
      chk("scrx_held", 32'(display_valid_o), 32'h1);
      frame();
      show(8'd0, 8'd0, 3);
      chk("scrx_col1", 32'(display_valid_o), 32'h0);
      chk_rd("scrx_read", 1'b0, 1'b1, 12'h001, 8'h08);

      // Vertical wrap at ROWS*8.
      wr(1'b0, 1'b1, 12'h002, 8'hF5);
      chk_rd("scry_fold", 1'b0, 1'b1, 12'h002, 8'h05);
      wr(1'b0, 1'b1, 12'h001, 8'h00);
      frame();
      show(8'd0, 8'd236, 3);
      chk("wrap_valid", 32'(display_valid_o), 32'h1);
      chk("wrap_color", 32'(display_color_o), 32'h1);

      // Frame counter: read-only and wraps.
      wr(1'b0, 1'b1, 12'h003, 8'h55);
      chk_rd("fcnt_ro", 1'b0, 1'b1, 12'h003, 8'h03);
      chk_rd("no_select", 1'b0, 1'b0, 12'h900, 8'h00);
      while (m_fcnt != 8'hFF) frame();
      chk_rd("fcnt_255", 1'b0, 1'b1, 12'h003, 8'hFF);
      frame();
      chk_rd("fcnt_wrap", 1'b0, 1'b1, 12'h003, 8'h00);

      // Blink.
      wr(1'b0, 1'b1, 12'h002, 8'h00);
      wr(1'b0, 1'b1, 12'h000, 8'h03);
      frame();
      show(8'd0, 8'd0, 3);
      chk("blink_on", 32'(display_valid_o), 32'h1);
      while (m_fcnt < 8'd16) frame();
      show(8'd0, 8'd0, 3);
      chk("blink_off", 32'(display_valid_o), 32'h0);
      show(8'd16, 8'd0, 3);
      chk("noblink_valid", 32'(display_valid_o), 32'h1);
      chk("noblink_color", 32'(display_color_o), 32'h0);
      while (m_fcnt < 8'd32) frame();
      show(8'd0, 8'd0, 3);
      chk("blink_back", 32'(display_valid_o), 32'h1);

      // Reset in the middle of active display.
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_now_valid", 32'(display_valid_o), 32'h0);
      chk("rst_now_color", 32'(display_color_o), 32'h0);
      chk_rd("rst_ctrl", 1'b0, 1'b1, 12'h000, 8'h01);
      chk_rd("rst_txbl", 1'b1, 1'b0, BASE, 8'h81);
      rst = 1'b0;
      frame_start_i = 1'b1;
      step();
      frame_start_i = 1'b0;
      chk("rst_first_edge", 32'(display_valid_o), 32'h0);
      step();
      chk("rst_second_edge", 32'(display_valid_o), 32'h1);

      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            vram_wen_i = 1'b0;
            rst = 1'b1;
            model_reset();
            #1;
            chk("rand_rst_valid", 32'(display_valid_o), 32'h0);
            step(); step();
            rst = 1'b0;
         end
         display_x_i    = 8'($urandom);
         display_y_i    = 8'($urandom);
         frame_start_i  = ($urandom_range(0, 39) == 0);
         vram_wen_i     = ($urandom_range(0, 3) == 0);
         {SELECT_txbl_i, SELECT_txctl_i} = 2'($urandom);
         vram_address_i = SELECT_txbl_i ? 12'(int'(BASE) + int'($urandom_range(0, 1023))) : 12'($urandom);
         vram_wdata_i   = 8'($urandom);
         #1;
         chk("rdata", 32'(vram_rdata_o), 32'(model_rdata()));
         step();
      end

      vram_wen_i = 1'b0; frame_start_i = 1'b0;
      SELECT_txbl_i = 1'b0; SELECT_txctl_i = 1'b0;
      step(); step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
